// File: rtl/pad_cfg_sequencer.sv
// Per-pad control owner for the bidirectional pad ring: a shadow config file written by software
// and a staged sequencer that copies it to the pads one group at a time with a settle gap.
module pad_cfg_sequencer #(
    parameter int NUM_PADS   = 43,
    parameter int GROUP_SIZE = 8,
    parameter int SETTLE_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [5:0]          cfg_addr_i,
    input  logic [5:0]          cfg_data_i,
    input  logic                apply_i,
    input  logic [SETTLE_W-1:0] settle_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                cfg_err_o,
    input  logic                err_clr_i,
    input  logic [5:0]          rd_addr_i,
    output logic [5:0]          rd_data_o,
    output logic [NUM_PADS-1:0] io_oe,
    output logic [NUM_PADS-1:0] io_ie,
    output logic [NUM_PADS-1:0] io_pu,
    output logic [NUM_PADS-1:0] io_pd,
    output logic [NUM_PADS-1:0] io_sl,
    output logic [NUM_PADS-1:0] io_cs
);
    localparam int NUM_GROUPS = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GROUP  = GW'(NUM_GROUPS - 1);
    // Config word layout is {cs, sl, pd, pu, ie, oe}; pads come out of reset as inputs only.
    localparam logic [5:0]    CFG_DEFAULT = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       group_q, group_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [5:0]          shadow_q [NUM_PADS];
    logic [5:0]          active_q [NUM_PADS];
    logic                err_q, err_d;
    logic [5:0]          rd_q, rd_d;

    logic                idle;
    logic                wr_fire;
    logic                addr_bad;
    logic                pupd_both;
    logic                err_set;
    logic [5:0]          wr_data;

    // ------------------------------------------------------------------
    // Apply sequencer
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            group_q  <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            group_q  <= group_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        group_d  = group_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (apply_i) begin
                    state_d  = ST_LOAD;
                    group_d  = '0;
                    settle_d = settle_i;
                end
            end
            ST_LOAD: begin
                if (settle_q != '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = settle_q;
                end else if (group_q == LAST_GROUP) begin
                    state_d = ST_DONE;
                end else begin
                    group_d = group_q + GW'(1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - SETTLE_W'(1);
                if (cnt_q == SETTLE_W'(1)) begin
                    if (group_q == LAST_GROUP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        group_d = group_q + GW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Registered flags: busy tracks the state being entered, done marks the exit from DONE.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Shadow writes and error flag
    // ------------------------------------------------------------------
    assign idle      = (state_q == ST_IDLE);
    assign wr_fire   = cfg_valid_i & idle;
    assign addr_bad  = (cfg_addr_i >= 6'(NUM_PADS));
    assign pupd_both = cfg_data_i[2] & cfg_data_i[3];
    assign err_set   = wr_fire & (addr_bad | pupd_both);
    assign err_d     = err_set | (err_q & ~err_clr_i);

    // Conflicting pull request resolves to pull-up so the pad never fights itself.
    always_comb begin
        wr_data = cfg_data_i;
        if (pupd_both) begin
            wr_data[3] = 1'b0;
        end
    end

    // NOTE: shadow and active files are reset because the pads must be at known defaults out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                shadow_q[p] <= CFG_DEFAULT;
                active_q[p] <= CFG_DEFAULT;
            end
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (wr_fire && (cfg_addr_i == 6'(p))) begin
                    shadow_q[p] <= wr_data;
                end
                if ((state_q == ST_LOAD) && (group_q == GW'(p / GROUP_SIZE))) begin
                    active_q[p] <= shadow_q[p];
                end
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (rd_addr_i == 6'(p)) begin
                rd_d = active_q[p];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
            rd_q  <= CFG_DEFAULT;
        end else begin
            err_q <= err_d;
            rd_q  <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_ready_o = idle;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = err_q;
    assign rd_data_o   = rd_q;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign io_oe[p] = active_q[p][0];
        assign io_ie[p] = active_q[p][1];
        assign io_pu[p] = active_q[p][2];
        assign io_pd[p] = active_q[p][3];
        assign io_sl[p] = active_q[p][4];
        assign io_cs[p] = active_q[p][5];
    end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Bench for pad_cfg_sequencer: directed and randomized writes/applies against a per-pad model
// whose pad timing is derived from the group arithmetic, not from any state machine.
module tb_pad_cfg_sequencer;
    localparam int NUM_PADS   = 43;
    localparam int GROUP_SIZE = 8;
    localparam int SETTLE_W   = 8;
    localparam int G          = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam logic [5:0] DEF = 6'b000010;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                cfg_valid_i;
    logic                cfg_ready_o;
    logic [5:0]          cfg_addr_i;
    logic [5:0]          cfg_data_i;
    logic                apply_i;
    logic [SETTLE_W-1:0] settle_i;
    logic                busy_o;
    logic                done_o;
    logic                cfg_err_o;
    logic                err_clr_i;
    logic [5:0]          rd_addr_i;
    logic [5:0]          rd_data_o;
    logic [NUM_PADS-1:0] io_oe, io_ie, io_pu, io_pd, io_sl, io_cs;

    pad_cfg_sequencer #(
        .NUM_PADS  (NUM_PADS),
        .GROUP_SIZE(GROUP_SIZE),
        .SETTLE_W  (SETTLE_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_addr_i (cfg_addr_i),
        .cfg_data_i (cfg_data_i),
        .apply_i    (apply_i),
        .settle_i   (settle_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cfg_err_o  (cfg_err_o),
        .err_clr_i  (err_clr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .io_oe      (io_oe),
        .io_ie      (io_ie),
        .io_pu      (io_pu),
        .io_pd      (io_pd),
        .io_sl      (io_sl),
        .io_cs      (io_cs)
    );

    always #5 clk_i = ~clk_i;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    logic [5:0] shadow_m [NUM_PADS];
    logic [5:0] active_m [NUM_PADS];
    logic       err_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [NUM_PADS-1:0] bus_of(input logic [5:0] a [NUM_PADS], input int k);
        logic [NUM_PADS-1:0] r;
        for (int p = 0; p < NUM_PADS; p++) r[p] = a[p][k];
        return r;
    endfunction

    function automatic logic [NUM_PADS-1:0] obs_bus(input int k);
        case (k)
            0:       return io_oe;
            1:       return io_ie;
            2:       return io_pu;
            3:       return io_pd;
            4:       return io_sl;
            default: return io_cs;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NUM_PADS; p++) begin
            shadow_m[p] = DEF;
            active_m[p] = DEF;
        end
        err_m = 1'b0;
    endtask

    // A write presented while the sequencer is idle; an error set beats a same-cycle clear.
    task automatic model_write(input logic [5:0] a, input logic [5:0] d, input bit clr);
        logic [5:0] v;
        if (clr) err_m = 1'b0;
        if (int'(a) >= NUM_PADS) begin
            err_m = 1'b1;
        end else begin
            v = d;
            if (d[2] && d[3]) begin
                v[3]  = 1'b0;
                err_m = 1'b1;
            end
            shadow_m[a] = v;
        end
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 6; k++)
            check($sformatf("%s bus%0d", tag, k), 64'(obs_bus(k)), 64'(bus_of(active_m, k)));
        check({tag, " busy"},  64'(busy_o),      64'(0));
        check({tag, " done"},  64'(done_o),      64'(0));
        check({tag, " ready"}, 64'(cfg_ready_o), 64'(1));
        check({tag, " err"},   64'(cfg_err_o),   64'(err_m));
    endtask

    task automatic wr(input logic [5:0] a, input logic [5:0] d, input bit clr);
        cfg_valid_i = 1'b1;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        err_clr_i   = clr;
        model_write(a, d, clr);
        tick();
        cfg_valid_i = 1'b0;
        err_clr_i   = 1'b0;
        check($sformatf("wr a%0d err", a), 64'(cfg_err_o), 64'(err_m));
    endtask

    task automatic rd(input logic [5:0] a);
        rd_addr_i = a;
        tick();
        check($sformatf("rd a%0d", a), 64'(rd_data_o), 64'(active_m[a]));
    endtask

    // Apply with settle s; pads of group g must switch at offset 1+g*(s+1) after the accept edge.
    // pulse_at / clr_at (offsets, -1 = none) inject an ignored apply+write or an err clear mid-run.
    task automatic apply_run(input int s, input bit wr_en, input logic [5:0] wa, input logic [5:0] wd,
                             input int pulse_at, input int clr_at, input string tag);
        logic [5:0]          old_a [NUM_PADS];
        logic [NUM_PADS-1:0] e;
        int                  last;
        old_a    = active_m;
        settle_i = SETTLE_W'(s);
        apply_i  = 1'b1;
        if (wr_en) begin
            cfg_valid_i = 1'b1;
            cfg_addr_i  = wa;
            cfg_data_i  = wd;
            model_write(wa, wd, 1'b0);
        end
        tick();
        apply_i     = 1'b0;
        cfg_valid_i = 1'b0;
        last        = G * (s + 1) + 1;
        for (int off = 0; off <= last + 1; off++) begin
            for (int k = 0; k < 6; k++) begin
                for (int p = 0; p < NUM_PADS; p++)
                    e[p] = (off >= 1 + (p / GROUP_SIZE) * (s + 1)) ? shadow_m[p][k] : old_a[p][k];
                check($sformatf("%s off%0d bus%0d", tag, off, k), 64'(obs_bus(k)), 64'(e));
            end
            check($sformatf("%s off%0d busy", tag, off),  64'(busy_o),      64'(off < last));
            check($sformatf("%s off%0d done", tag, off),  64'(done_o),      64'(off == last));
            check($sformatf("%s off%0d ready", tag, off), 64'(cfg_ready_o), 64'(off >= last));
            check($sformatf("%s off%0d err", tag, off),   64'(cfg_err_o),   64'(err_m));
            apply_i     = 1'b0;
            cfg_valid_i = 1'b0;
            err_clr_i   = 1'b0;
            if (off == pulse_at) begin
                apply_i     = 1'b1;
                settle_i    = '0;
                cfg_valid_i = 1'b1;
                cfg_addr_i  = 6'd0;
                cfg_data_i  = 6'b010001;
            end
            if (off == clr_at) begin
                err_clr_i = 1'b1;
                err_m     = 1'b0;
            end
            tick();
        end
        apply_i     = 1'b0;
        cfg_valid_i = 1'b0;
        err_clr_i   = 1'b0;
        active_m    = shadow_m;
    endtask

    initial begin
        int         s, last, pa, ca, n;
        logic [5:0] a, d;

        rst_i       = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_addr_i  = '0;
        cfg_data_i  = '0;
        apply_i     = 1'b0;
        settle_i    = '0;
        err_clr_i   = 1'b0;
        rd_addr_i   = '0;
        model_reset();
        #2;
        check_idle("reset");
        check("reset rd", 64'(rd_data_o), 64'(DEF));
        tick();
        rst_i = 1'b0;

        // Basic apply with no settle gap.
        wr(6'd5, 6'b000011, 1'b0);
        wr(6'd42, 6'b100101, 1'b0);
        apply_run(0, 1'b0, '0, '0, -1, -1, "s0");
        check_idle("s0 idle");
        rd(6'd5);
        rd(6'd42);

        // One changed pad per group, settle gap 3, ignored apply/write while busy.
        for (int g = 0; g < G; g++) wr(6'(g * GROUP_SIZE + 1), 6'b010001, 1'b0);
        apply_run(3, 1'b0, '0, '0, 5, -1, "s3");
        check_idle("s3 idle");
        rd(6'd0);
        rd(6'd17);

        // Error handling.
        wr(6'd43, 6'b000001, 1'b0);
        wr(6'd7, 6'b001101, 1'b0);
        wr(6'd44, 6'b000001, 1'b1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        err_m     = 1'b0;
        check("err clr", 64'(cfg_err_o), 64'(0));
        apply_run(1, 1'b0, '0, '0, -1, -1, "pupd");
        rd(6'd7);
        check("pupd resolved", 64'(rd_data_o), 64'(6'b000101));
        wr(6'd50, 6'b000000, 1'b0);
        apply_run(2, 1'b0, '0, '0, -1, 2, "clrbusy");

        // Write in the same cycle as apply is part of that apply.
        apply_run(0, 1'b1, 6'd0, 6'b110001, 3, -1, "same");
        rd(6'd0);

        // Reset during the gap after group 3.
        for (int p = 0; p < NUM_PADS; p++) wr(6'(p), 6'b010101, 1'b0);
        settle_i = 8'd3;
        apply_i  = 1'b1;
        tick();
        apply_i = 1'b0;
        repeat (14) tick();
        check("pre-rst group3 oe", 64'(io_oe[31:24]), 64'(8'hff));
        rst_i = 1'b1;
        #1;
        model_reset();
        check_idle("midrst");
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            check($sformatf("postrst c%0d", i), 64'({busy_o, done_o, io_oe}), 64'(0));
            tick();
        end
        check_idle("postrst");

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                a = 6'($urandom_range(0, 50));
                d = 6'($urandom);
                wr(a, d, ($urandom_range(0, 3) == 0));
            end
            s    = int'($urandom_range(0, 3));
            last = G * (s + 1) + 1;
            pa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last - 1)) : -1;
            ca   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, last)) : -1;
            apply_run(s, ($urandom_range(0, 1) == 1), 6'($urandom_range(0, 47)), 6'($urandom),
                      pa, ca, $sformatf("rnd%0d", r));
            for (int i = 0; i < 3; i++) rd(6'($urandom_range(0, NUM_PADS - 1)));
            check_idle($sformatf("rnd%0d idle", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
